// File: rtl/computing_cascade.sv
// Two-channel single-bin DFT feeding a per-channel CORDIC in vectoring mode.
// Reports the phase difference X2-X1 and the unscaled magnitude of X1 once per frame.
module computing_cascade #(
    parameter int unsigned W_WIDTH      = 16,
    parameter int unsigned X_WIDTH      = 16,
    parameter int unsigned S_WIDTH      = 38,
    parameter int unsigned FRAME_LENGTH = 33,
    parameter int unsigned NSTAGES      = 21
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_vld,
    input  logic signed [X_WIDTH-1:0] x1,
    input  logic signed [X_WIDTH-1:0] x2,
    output logic signed [31:0]        delta_ph,
    output logic        [31:0]        mag,
    output logic                      o_vld
);

    localparam int unsigned CW = S_WIDTH + 2;
    localparam int unsigned PW = X_WIDTH + W_WIDTH;
    localparam int unsigned NW = $clog2(FRAME_LENGTH);
    localparam int unsigned IW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
    localparam real Pi  = 3.14159265358979323846;
    localparam real Amp = (2.0 ** (W_WIDTH - 1)) - 1.0;

    typedef enum logic [1:0] {StIdle, StPre, StIter, StOut} state_e;

    logic signed [W_WIDTH-1:0] cos_tab [FRAME_LENGTH];
    logic signed [W_WIDTH-1:0] sin_tab [FRAME_LENGTH];
    logic        [31:0]        atan_tab [NSTAGES];

    // Real-valued math only runs at elaboration; the tables are constants in hardware.
    for (genvar g = 0; g < FRAME_LENGTH; g++) begin : g_weight
        localparam real    Ang  = 2.0 * Pi * real'(g) / real'(FRAME_LENGTH);
        localparam longint CosI = longint'(Amp * $cos(Ang));
        localparam longint SinI = longint'(Amp * $sin(Ang));
        assign cos_tab[g] = W_WIDTH'(CosI);
        assign sin_tab[g] = W_WIDTH'(SinI);
    end

    for (genvar g = 0; g < NSTAGES; g++) begin : g_atan
        localparam real    Ang   = $atan(2.0 ** (-real'(g)));
        localparam longint AtanI = longint'(Ang * 4294967296.0 / (2.0 * Pi));
        assign atan_tab[g] = 32'(AtanI);
    end

    logic signed [X_WIDTH-1:0] xs [2];
    logic signed [PW-1:0]      pc [2];
    logic signed [PW-1:0]      ps [2];
    logic signed [S_WIDTH-1:0] re_q [2];
    logic signed [S_WIDTH-1:0] im_q [2];
    logic signed [S_WIDTH-1:0] re_sum [2];
    logic signed [S_WIDTH-1:0] im_sum [2];
    logic signed [S_WIDTH-1:0] in_re_q [2];
    logic signed [S_WIDTH-1:0] in_im_q [2];
    logic        [NW-1:0]      n_q;
    logic                      frame_end;

    assign xs[0]     = x1;
    assign xs[1]     = x2;
    assign frame_end = i_vld && (n_q == NW'(FRAME_LENGTH - 1));

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            pc[k]     = PW'(xs[k]) * PW'(cos_tab[n_q]);
            ps[k]     = PW'(xs[k]) * PW'(sin_tab[n_q]);
            re_sum[k] = re_q[k] + S_WIDTH'(pc[k]);
            im_sum[k] = im_q[k] - S_WIDTH'(ps[k]);
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            n_q <= '0;
            for (int k = 0; k < 2; k++) begin
                re_q[k]    <= '0;
                im_q[k]    <= '0;
                in_re_q[k] <= '0;
                in_im_q[k] <= '0;
            end
        end else if (i_vld) begin
            if (frame_end) begin
                // Final sums go to the CORDIC; accumulators restart with the next sample.
                n_q <= '0;
                for (int k = 0; k < 2; k++) begin
                    re_q[k]    <= '0;
                    im_q[k]    <= '0;
                    in_re_q[k] <= re_sum[k];
                    in_im_q[k] <= im_sum[k];
                end
            end else begin
                n_q <= n_q + NW'(1);
                for (int k = 0; k < 2; k++) begin
                    re_q[k] <= re_sum[k];
                    im_q[k] <= im_sum[k];
                end
            end
        end
    end

    state_e          state_q, state_d;
    logic   [IW-1:0] iter_q, iter_d;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= StIdle;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            StIdle: if (frame_end) state_d = StPre;
            StPre: begin
                state_d = StIter;
                iter_d  = '0;
            end
            StIter: begin
                if (iter_q == IW'(NSTAGES - 1)) state_d = StOut;
                else iter_d = iter_q + IW'(1);
            end
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    logic signed [CW-1:0] cx_q [2];
    logic signed [CW-1:0] cy_q [2];
    logic        [31:0]   cz_q [2];
    logic signed [CW-1:0] cx_d [2];
    logic signed [CW-1:0] cy_d [2];
    logic        [31:0]   cz_d [2];
    logic signed [CW-1:0] re_ext [2];
    logic signed [CW-1:0] im_ext [2];
    logic signed [CW-1:0] x_sh [2];
    logic signed [CW-1:0] y_sh [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cx_d[k]   = cx_q[k];
            cy_d[k]   = cy_q[k];
            cz_d[k]   = cz_q[k];
            re_ext[k] = CW'(in_re_q[k]);
            im_ext[k] = CW'(in_im_q[k]);
            x_sh[k]   = cx_q[k] >>> iter_q;
            y_sh[k]   = cy_q[k] >>> iter_q;
            case (state_q)
                StPre: begin
                    // Fold the left half-plane onto the right so the iterations converge.
                    if (in_re_q[k][S_WIDTH-1]) begin
                        cx_d[k] = -re_ext[k];
                        cy_d[k] = -im_ext[k];
                        cz_d[k] = 32'h8000_0000;
                    end else begin
                        cx_d[k] = re_ext[k];
                        cy_d[k] = im_ext[k];
                        cz_d[k] = '0;
                    end
                end
                StIter: begin
                    if (cy_q[k][CW-1]) begin
                        cx_d[k] = cx_q[k] - y_sh[k];
                        cy_d[k] = cy_q[k] + x_sh[k];
                        cz_d[k] = cz_q[k] - atan_tab[iter_q];
                    end else begin
                        cx_d[k] = cx_q[k] + y_sh[k];
                        cy_d[k] = cy_q[k] - x_sh[k];
                        cz_d[k] = cz_q[k] + atan_tab[iter_q];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int k = 0; k < 2; k++) begin
                cx_q[k] <= '0;
                cy_q[k] <= '0;
                cz_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                cx_q[k] <= cx_d[k];
                cy_q[k] <= cy_d[k];
                cz_q[k] <= cz_d[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            delta_ph <= '0;
            mag      <= '0;
            o_vld    <= 1'b0;
        end else begin
            o_vld <= (state_q == StOut);
            if (state_q == StOut) begin
                delta_ph <= cz_q[1] - cz_q[0];
                mag      <= (|cx_q[0][CW-1:32]) ? '1 : cx_q[0][31:0];
            end
        end
    end

endmodule

// File: tb/tb_computing_cascade.sv
// Randomised bench for computing_cascade: exact DFT sums in the bench, then
// polar conversion with real math, compared against the DUT with tolerances.
module tb_computing_cascade;

    localparam int N   = 33;
    localparam int NST = 21;
    localparam real Pi = 3.14159265358979323846;

    typedef struct {
        longint re1;
        longint im1;
        longint re2;
        longint im2;
        int     last_edge;
        bit     same;
        bit     has_ref;
        int     ph_ref;
    } frame_t;

    logic               clk;
    logic               rstn;
    logic               i_vld;
    logic signed [15:0] x1;
    logic signed [15:0] x2;
    logic signed [31:0] delta_ph;
    logic        [31:0] mag;
    logic               o_vld;

    computing_cascade dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_vld    (i_vld),
        .x1       (x1),
        .x2       (x2),
        .delta_ph (delta_ph),
        .mag      (mag),
        .o_vld    (o_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     edge_cnt = 0;
    int     n_checks = 0;
    int     n_err    = 0;
    int     n_pulse  = 0;
    int     n_frames = 0;
    longint wc [N];
    longint ws [N];
    int     f1 [N];
    int     f2 [N];
    real    kgain;
    frame_t exp_q [$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input longint got, input longint exp,
                         input longint tol, input bit wrap);
        longint d;
        d = got - exp;
        if (wrap) d = longint'(int'(d));
        if (d < 0) d = -d;
        n_checks++;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Result monitor: polar form of the exact sums, computed with real arithmetic.
    frame_t mr;
    real    a1, a2, mreal;
    longint e_mag, e_tol;
    int     e_ph;
    always @(negedge clk) begin
        if (o_vld) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                check("spurious_o_vld", 1, 0, 0, 0);
            end else begin
                mr = exp_q.pop_front();
                check("latency", longint'(edge_cnt - mr.last_edge), NST + 2, 0, 0);
                a1 = $atan2(real'(mr.im1), real'(mr.re1));
                a2 = $atan2(real'(mr.im2), real'(mr.re2));
                e_ph = int'(longint'((a2 - a1) / (2.0 * Pi) * 4294967296.0));
                check("delta_ph", longint'(delta_ph), longint'(e_ph), mr.same ? 0 : 4096, 1);
                mreal = kgain * $sqrt(real'(mr.re1) * real'(mr.re1)
                                      + real'(mr.im1) * real'(mr.im1));
                e_mag = (mreal > 4294967295.0) ? 64'd4294967295 : longint'(mreal);
                e_tol = longint'(real'(e_mag) * 1.0e-5) + 256;
                check("mag", longint'(mag), e_mag, e_tol, 0);
                if (mr.has_ref) check("delta_ph_ref", longint'(delta_ph), longint'(mr.ph_ref),
                                      4096, 1);
            end
        end
    end

    task automatic drive(input int a, input int b);
        @(negedge clk);
        i_vld = 1'b1;
        x1    = 16'(a);
        x2    = 16'(b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            i_vld = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // gap < 0 picks a random 0..3 idle cycles between samples.
    task automatic run_frame(input int gap, input bit has_ref, input int ph_ref);
        frame_t r;
        r.re1 = 0; r.im1 = 0; r.re2 = 0; r.im2 = 0;
        r.same = 1'b1; r.has_ref = has_ref; r.ph_ref = ph_ref; r.last_edge = 0;
        for (int n = 0; n < N; n++) begin
            r.re1 += longint'(f1[n]) * wc[n];
            r.im1 -= longint'(f1[n]) * ws[n];
            r.re2 += longint'(f2[n]) * wc[n];
            r.im2 -= longint'(f2[n]) * ws[n];
            if (f1[n] != f2[n]) r.same = 1'b0;
            drive(f1[n], f2[n]);
            if (n == N - 1) begin
                r.last_edge = edge_cnt;
                exp_q.push_back(r);
                n_frames++;
            end else begin
                idle((gap < 0) ? int'($urandom_range(3)) : gap);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
        check("drain_timeout", longint'(exp_q.size()), 0, 0, 0);
    endtask

    initial begin
        rstn  = 1'b1;
        i_vld = 1'b0;
        x1    = '0;
        x2    = '0;
        kgain = 1.0;
        for (int i = 0; i < NST; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * real'(i)));
        for (int n = 0; n < N; n++) begin
            wc[n] = longint'(32767.0 * $cos(2.0 * Pi * real'(n) / real'(N)));
            ws[n] = longint'(32767.0 * $sin(2.0 * Pi * real'(n) / real'(N)));
        end

        repeat (3) @(negedge clk);
        check("rst_delta_ph", longint'(delta_ph), 0, 0, 0);
        check("rst_mag", longint'(mag), 0, 0, 0);
        check("rst_o_vld", longint'(o_vld), 0, 0, 0);
        rstn = 1'b0;

        for (int n = 0; n < N; n++) begin
            f1[n] = int'(longint'(1000.0 * $cos(2.0 * Pi * real'(n) / real'(N))));
            f2[n] = f1[n];
        end
        run_frame(0, 1'b1, 0);
        drain();
        for (int n = 0; n < N; n++) f2[n] = -f1[n];
        run_frame(0, 1'b1, int'(32'h8000_0000));
        for (int n = 0; n < N; n++)
            f2[n] = int'(longint'(1000.0 * $sin(2.0 * Pi * real'(n) / real'(N))));
        run_frame(0, 1'b1, -1073741824);
        drain();

        for (int n = 0; n < N; n++) begin
            f1[n] = n;
            f2[n] = 2 * n;
        end
        run_frame(8, 1'b0, 0);
        run_frame(0, 1'b0, 0);
        run_frame(0, 1'b0, 0);
        drain();

        for (int f = 0; f < 5; f++) begin
            for (int n = 0; n < N; n++) begin
                if (f == 4) begin
                    f1[n] = int'($urandom_range(2000)) - 1000;
                end else begin
                    f1[n] = int'($urandom_range(65535)) - 32768;
                end
                f2[n] = (f == 2) ? f1[n] : int'($urandom_range(65535)) - 32768;
            end
            run_frame(-1, 1'b0, 0);
        end
        drain();

        for (int n = 0; n < 10; n++)
            drive(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
        @(negedge clk);
        i_vld = 1'b0;
        rstn  = 1'b1;
        #1;
        check("midrst_delta_ph", longint'(delta_ph), 0, 0, 0);
        check("midrst_mag", longint'(mag), 0, 0, 0);
        @(negedge clk);
        rstn = 1'b0;
        for (int n = 0; n < N; n++) begin
            f1[n] = 0;
            f2[n] = 0;
        end
        run_frame(0, 1'b1, 0);
        drain();
        idle(30);

        check("o_vld_count", longint'(n_pulse), longint'(n_frames), 0, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/computing_cascade.md
Name: computing_cascade

Overview:
- Two-channel single-bin DFT followed by CORDIC vectoring for phase-difference and magnitude measurement.
- Correlates each FRAME_LENGTH-sample frame of x1 and x2 against one period of cos/sin.
- Converts both complex results to polar form and reports the phase difference x2−x1 and the magnitude of x1, once per frame.
- Sits between the ADC sample stream and the measurement/readout logic of the spectral-phase path.

Parameters:
- W_WIDTH, 16: signed width of the cos/sin weights. Q1.(W_WIDTH−1), amplitude 2^(W_WIDTH−1)−1.
- X_WIDTH, 16: signed width of the input samples.
- S_WIDTH, 38: signed width of the DFT accumulators. Must be ≥ X_WIDTH+W_WIDTH+ceil(log2(FRAME_LENGTH)).
- FRAME_LENGTH, 33: samples per frame (N). Must be ≥ NSTAGES+3.
- NSTAGES, 21: number of CORDIC micro-rotations.

Ports:
- clk, input, 1: single clock, rising edge.
- rstn, input, 1: reset, asynchronous and active-high. Asserted when 1, despite the name.
- i_vld, input, 1: the sample on x1/x2 is accepted on a rising edge where i_vld=1.
- x1, input, X_WIDTH signed: channel 1 sample.
- x2, input, X_WIDTH signed: channel 2 sample.
- delta_ph, output, 32 signed: phase(X2) − phase(X1) as a binary angle. 2^32 LSB = 2π; wraps modulo 2^32.
- mag, output, 32 unsigned: CORDIC magnitude of X1.
- o_vld, output, 1: one-cycle strobe; delta_ph/mag are valid in that cycle.

Behaviour:
- Reset (rstn=1, asynchronous) clears:
  - the sample index n;
  - all accumulators and CORDIC state;
  - delta_ph=0, mag=0, o_vld=0.
  - Reset mid-frame discards the partial frame; the next accepted sample is n=0.
- Weights:
  - Table of FRAME_LENGTH entries computed at elaboration.
  - C[n]=round((2^(W_WIDTH−1)−1)·cos(2πn/N)).
  - S[n]=round((2^(W_WIDTH−1)−1)·sin(2πn/N)).
- DFT accumulation, per accepted sample:
  - Re_k += xk·C[n]; Im_k −= xk·S[n], for k = 1, 2.
  - Full-precision products, S_WIDTH accumulators.
  - n increments and wraps from N−1 to 0.
  - i_vld may be sparse (arbitrary gaps) or continuous; idle cycles change nothing.
- Frame end, on the cycle the sample with n=N−1 is accepted:
  - The final sums (including that sample) are transferred to the CORDIC input registers.
  - The accumulators restart from zero with the next sample, so back-to-back frames lose no samples.
- CORDIC, per channel (two instances or a shared datapath, same result):
  - Internal width S_WIDTH+2.
  - Pre-rotation: if Re<0, negate Re and Im and start z=0x80000000; else z=0.
  - Iteration i=0..NSTAGES−1, direction d=+1 if y<0 else −1:
    - x −= d·(y>>>i)
    - y += d·(x>>>i)
    - z −= d·atan_i
  - atan_i = round(atan(2^−i)·2^32/(2π)), 32-bit table.
  - One iteration per clock.
- Outputs:
  - delta_ph = z2 − z1, modulo 2^32.
  - mag = final x of channel 1. Not gain-compensated (≈1.64676·|X1|); saturated to 2^32−1.
- Timing:
  - Last sample accepted at edge T.
  - Pre-rotation registered at T+1.
  - Iterations at T+2..T+NSTAGES+1.
  - Outputs registered and o_vld=1 for exactly one cycle at T+NSTAGES+2.
  - Latency is independent of input gaps.
- Hold and pipelining:
  - delta_ph/mag hold their values until the next o_vld.
  - A new frame completing while the CORDIC is busy cannot happen, since FRAME_LENGTH ≥ NSTAGES+3.
- Identical X1 and X2 give delta_ph exactly 0, including all-zero input.

Test Plan:
- Reset asserted → outputs 0 and o_vld 0. Reset released and 33 samples fed with continuous i_vld → exactly one o_vld, 23 cycles after the 33rd sample edge.
- x1[n]=x2[n]=round(1000·cos(2πn/33)), continuous → delta_ph=0 exactly; mag≈1.64676·1000·32767·16.5 ≈ 8.90e8, within 0.1%.
- x1 as above, x2=−x1 → delta_ph within ±2^12 of 0x80000000 (±π).
- x2[n]=round(1000·sin(2πn/33)) → delta_ph ≈ −2^30 (−π/2), within ±2^12.
- Ramp stimulus (x1+=1, x2+=2): one frame with i_vld every 9th cycle, then two frames back-to-back → three o_vld pulses, each at fixed latency. Back-to-back result equals the sparse-frame result for identical data.
- Reset pulsed mid-frame after 10 samples, then 33 zero samples → a single o_vld with mag=0, delta_ph=0.
